// File: rtl/jtg_mst_avmm_arbiter.sv
// Two-requester Avalon-MM arbiter: round-robin command grant, in-order read return routed by an ID FIFO.
// Grant is registered, so it arrives 1 cycle after a request; a granted requester stalls on m_waitrequest or a full ID FIFO.
module jtg_mst_avmm_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [ADDR_W-1:0]          s0_address,
  input  logic                       s0_read,
  input  logic                       s0_write,
  input  logic [DATA_W-1:0]          s0_writedata,
  input  logic [DATA_W/8-1:0]        s0_byteenable,
  output logic                       s0_waitrequest,
  output logic [DATA_W-1:0]          s0_readdata,
  output logic                       s0_readdatavalid,
  input  logic [ADDR_W-1:0]          s1_address,
  input  logic                       s1_read,
  input  logic                       s1_write,
  input  logic [DATA_W-1:0]          s1_writedata,
  input  logic [DATA_W/8-1:0]        s1_byteenable,
  output logic                       s1_waitrequest,
  output logic [DATA_W-1:0]          s1_readdata,
  output logic                       s1_readdatavalid,
  output logic [ADDR_W-1:0]          m_address,
  output logic                       m_read,
  output logic                       m_write,
  output logic [DATA_W-1:0]          m_writedata,
  output logic [DATA_W/8-1:0]        m_byteenable,
  input  logic                       m_waitrequest,
  input  logic [DATA_W-1:0]          m_readdata,
  input  logic                       m_readdatavalid,
  output logic [$clog2(MAX_PEND):0]  pend_count,
  output logic [1:0]                 err_sticky
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(MAX_PEND);
  localparam logic [PW:0] PEND_MAX = (PW+1)'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t            state;
  logic              last_grant;
  logic              id_mem [MAX_PEND];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic req0, req1, gnt0, gnt1, sel_read, sel_write;
  logic full, empty, blk, accept, push, pop, head, pop0, pop1;

  assign req0      = s0_read | s0_write;
  assign req1      = s1_read | s1_write;
  assign gnt0      = (state == GNT0);
  assign gnt1      = (state == GNT1);
  assign sel_read  = (gnt0 & s0_read)  | (gnt1 & s1_read);
  assign sel_write = (gnt0 & s0_write) | (gnt1 & s1_write);

  // full comes from the registered count, so a pop this cycle cannot release a blocked read until next cycle
  assign full  = (pend_count == PEND_MAX);
  assign empty = (pend_count == '0);
  assign blk   = sel_read & full;

  assign m_read       = sel_read & ~full;
  assign m_write      = sel_write & ~sel_read;
  assign m_address    = gnt0 ? s0_address    : gnt1 ? s1_address    : addr_q;
  assign m_writedata  = gnt0 ? s0_writedata  : gnt1 ? s1_writedata  : wdata_q;
  assign m_byteenable = gnt0 ? s0_byteenable : gnt1 ? s1_byteenable : be_q;

  assign accept = (m_read | m_write) & ~m_waitrequest;
  assign push   = m_read & ~m_waitrequest;
  assign pop    = m_readdatavalid & ~empty;
  assign head   = id_mem[rd_ptr];
  assign pop0   = pop & ~head;
  assign pop1   = pop & head;

  assign s0_waitrequest   = gnt0 ? (m_waitrequest | blk) : 1'b1;
  assign s1_waitrequest   = gnt1 ? (m_waitrequest | blk) : 1'b1;
  assign s0_readdatavalid = pop0;
  assign s1_readdatavalid = pop1;
  assign s0_readdata      = pop0 ? m_readdata : rdata0_q;
  assign s1_readdata      = pop1 ? m_readdata : rdata1_q;

  always_ff @(posedge clk_clk) begin
    if (push) id_mem[wr_ptr] <= gnt1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_count <= '0;
      err_sticky <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        addr_q  <= m_address;
        wdata_q <= m_writedata;
        be_q    <= m_byteenable;
      end
      if (pop0) rdata0_q <= m_readdata;
      if (pop1) rdata1_q <= m_readdata;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pend_count <= pend_count + 1'b1;
        2'b01:   pend_count <= pend_count - 1'b1;
        default: pend_count <= pend_count;
      endcase
      if (m_readdatavalid & empty) err_sticky[0] <= 1'b1;
      if (sel_read & sel_write)    err_sticky[1] <= 1'b1;

      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_grant)) state <= GNT0;
          else if (req1)                     state <= GNT1;
        end
        GNT0: begin
          if (accept) begin
            last_grant <= 1'b0;
            state      <= req1 ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (accept) begin
            last_grant <= 1'b1;
            state      <= req0 ? GNT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
